// File: rtl/coax_tx_pkg.sv
// Shared types and constants for the coax line transmitter.
//   tx_state_t  : framer state encoding
//   tx_word_t   : one held host word (data, parity flip, last-of-frame flag)
//   word_parity : parity bit appended after the data bits
package coax_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_PRE,
    START_ONES,
    START_LOW,
    START_HIGH,
    WORD,
    END_BIT,
    END_HIGH
  } tx_state_t;

  localparam int START_ONES_COUNT = 5;
  localparam int WORD_BITS        = 12;
  localparam int DATA_BITS        = 10;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 par_inv;
    logic                 last;
  } tx_word_t;

  function automatic logic word_parity(input logic [DATA_BITS-1:0] data,
                                       input logic odd,
                                       input logic inv);
    return (^data) ^ odd ^ inv;
  endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Half-bit / bit / 3-half-bit timing generator for the coax framer.
//   clk, reset_n : clock, synchronous active-low reset
//   restart      : zero all counters at this edge (framer asserts it on
//                  every state change so each state starts on a fresh bit)
//   half_tick    : last cycle of a half bit
//   bit_tick     : last cycle of a full bit (second half ending)
//   long_tick    : last cycle of a 3H interval
module coax_tx_bit_timer #(
  parameter int HALF_BIT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic half_tick,
  output logic bit_tick,
  output logic long_tick
);

  localparam int CW = $clog2(3 * HALF_BIT_CYCLES);

  logic [CW-1:0] half_cnt;
  logic          phase;     // 0 = first half of the bit, 1 = second half
  logic [1:0]    half_num;  // half bits elapsed mod 3, for the long tick

  assign half_tick = (half_cnt == CW'(HALF_BIT_CYCLES - 1));
  assign bit_tick  = half_tick & phase;
  assign long_tick = half_tick & (half_num == 2'd2);

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      half_cnt <= '0;
      phase    <= 1'b0;
      half_num <= 2'd0;
    end else if (half_tick) begin
      half_cnt <= '0;
      phase    <= ~phase;
      half_num <= (half_num == 2'd2) ? 2'd0 : half_num + 2'd1;
    end else begin
      half_cnt <= half_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/coax_tx_framer.sv
// Coax line transmitter: accepts 10-bit words over valid/ready, frames
// them as start sequence, 12-bit words {sync, data, parity}, end sequence,
// and drives a registered line output.
//   clk, reset_n      : clock, synchronous active-low reset
//   tx_data           : word to send, bit 9 first
//   tx_parity_invert  : flip the generated parity of this word
//   tx_last           : this word closes the frame
//   tx_valid/tx_ready : handshake into the one-entry holding register
//   tx                : line output, idle low
//   tx_active         : framer busy (state not IDLE)
//   tx_underflow      : pulse when a non-last word ends with nothing held
module coax_tx_framer
  import coax_tx_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 8,
  parameter bit PARITY_ODD      = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_parity_invert,
  input  logic                 tx_last,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_active,
  output logic                 tx_underflow
);

  tx_state_t            state;
  tx_word_t             hold;
  logic                 hold_valid;
  logic                 cur_last;
  logic [WORD_BITS-1:0] sreg;
  logic [3:0]           bit_cnt;
  logic                 second_half;
  logic                 done;
  logic                 tx_next;
  logic                 half_tick, bit_tick, long_tick;

  coax_tx_bit_timer #(.HALF_BIT_CYCLES(HALF_BIT_CYCLES)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (done),
    .half_tick (half_tick),
    .bit_tick  (bit_tick),
    .long_tick (long_tick)
  );

  assign tx_ready  = ~hold_valid;
  assign tx_active = (state != IDLE);

  // done marks the last cycle of the current state (or of a word when it
  // reloads back-to-back); tx_next is the line level for this cycle, which
  // appears on tx one cycle later.
  always_comb begin
    done    = 1'b0;
    tx_next = 1'b0;
    case (state)
      IDLE:       done = hold_valid;
      START_PRE:  begin done = bit_tick; tx_next = 1'b1; end
      START_ONES: begin
        done    = bit_tick && (bit_cnt == 4'(START_ONES_COUNT - 1));
        tx_next = second_half;
      end
      START_LOW:  done = long_tick;
      START_HIGH: begin done = long_tick; tx_next = 1'b1; end
      WORD: begin
        done    = bit_tick && (bit_cnt == 4'(WORD_BITS - 1));
        tx_next = second_half ? sreg[WORD_BITS-1] : ~sreg[WORD_BITS-1];
      end
      END_BIT:    begin done = bit_tick; tx_next = ~second_half; end
      END_HIGH:   begin done = bit_tick; tx_next = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold         <= '0;
      hold_valid   <= 1'b0;
      cur_last     <= 1'b0;
      sreg         <= '0;
      bit_cnt      <= '0;
      second_half  <= 1'b0;
      tx           <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      tx           <= tx_next;
      tx_underflow <= 1'b0;

      if (done)           second_half <= 1'b0;
      else if (half_tick) second_half <= ~second_half;

      if (done) bit_cnt <= '0;

      // Accept and load are mutually exclusive: accept needs an empty
      // holding register, load needs a full one.
      if (tx_valid && !hold_valid) begin
        hold       <= '{data: tx_data, par_inv: tx_parity_invert, last: tx_last};
        hold_valid <= 1'b1;
      end

      case (state)
        IDLE: if (hold_valid) state <= START_PRE;
        START_PRE: if (bit_tick) state <= START_ONES;
        START_ONES: if (bit_tick) begin
          if (done) state <= START_LOW;
          else      bit_cnt <= bit_cnt + 4'd1;
        end
        START_LOW: if (long_tick) state <= START_HIGH;
        START_HIGH: if (long_tick) begin
          state      <= WORD;
          sreg       <= {1'b1, hold.data, word_parity(hold.data, PARITY_ODD, hold.par_inv)};
          cur_last   <= hold.last;
          hold_valid <= 1'b0;
        end
        WORD: if (bit_tick) begin
          if (!done) begin
            sreg    <= {sreg[WORD_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (cur_last) begin
            state <= END_BIT;
          end else if (hold_valid) begin
            sreg       <= {1'b1, hold.data, word_parity(hold.data, PARITY_ODD, hold.par_inv)};
            cur_last   <= hold.last;
            hold_valid <= 1'b0;
          end else begin
            tx_underflow <= 1'b1;
            state        <= END_BIT;
          end
        end
        END_BIT:  if (bit_tick) state <= END_HIGH;
        END_HIGH: if (bit_tick) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coax_tx_framer.sv
module tb_coax_tx_framer;

  localparam int H    = 8;
  localparam bit PODD = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [9:0] tx_data;
  logic       tx_parity_invert, tx_last, tx_valid;
  logic       tx_ready, tx, tx_active, tx_underflow;

  logic [9:0] d2_data;
  logic       d2_inv, d2_last, d2_valid;
  logic       d2_ready, d2_tx, d2_active, d2_uf;

  coax_tx_framer #(.HALF_BIT_CYCLES(H), .PARITY_ODD(PODD)) u_dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data),
    .tx_parity_invert(tx_parity_invert), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_active(tx_active), .tx_underflow(tx_underflow));

  coax_tx_framer #(.HALF_BIT_CYCLES(2), .PARITY_ODD(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .tx_data(d2_data),
    .tx_parity_invert(d2_inv), .tx_last(d2_last), .tx_valid(d2_valid),
    .tx_ready(d2_ready), .tx(d2_tx), .tx_active(d2_active), .tx_underflow(d2_uf));

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (line waveform as a queue) ----------
  typedef enum {S_NONE, S_START, S_WORD, S_END} seg_t;
  seg_t       seg = S_NONE;
  bit         q[$];
  bit         m_hv = 0, m_inv = 0, m_last = 0, m_cur_last = 0;
  bit [9:0]   m_d = '0;
  bit         e_tx = 0, e_act = 0, e_uf = 0, e_rdy = 1;
  bit         model_on = 0;

  function automatic void push_bit(bit b);
    repeat (H) q.push_back(!b);
    repeat (H) q.push_back(b);
  endfunction

  function automatic void push_start();
    repeat (2*H) q.push_back(1'b1);
    repeat (5) push_bit(1'b1);
    repeat (3*H) q.push_back(1'b0);
    repeat (3*H) q.push_back(1'b1);
  endfunction

  function automatic void push_word(bit [9:0] d, bit inv);
    push_bit(1'b1);
    for (int i = 9; i >= 0; i--) push_bit(d[i]);
    push_bit((^d) ^ PODD ^ inv);
  endfunction

  function automatic void push_end();
    push_bit(1'b0);
    repeat (2*H) q.push_back(1'b1);
  endfunction

  function automatic void load_word();
    push_word(m_d, m_inv);
    m_cur_last = m_last;
    m_hv = 0;
    seg = S_WORD;
  endfunction

  always @(posedge clk) begin
    bit cur, ready_old;
    e_uf = 0;
    if (!reset_n) begin
      q.delete(); seg = S_NONE; m_hv = 0; e_tx = 0;
    end else begin
      cur = (seg == S_NONE) ? 1'b0 : q[0];
      if (seg != S_NONE) void'(q.pop_front());
      ready_old = !m_hv;
      if (seg == S_NONE) begin
        if (m_hv) begin seg = S_START; push_start(); end
      end else if (q.size() == 0) begin
        case (seg)
          S_START: load_word();
          S_WORD: begin
            if (m_cur_last)  begin seg = S_END; push_end(); end
            else if (m_hv)   load_word();
            else begin e_uf = 1; seg = S_END; push_end(); end
          end
          default: seg = S_NONE;
        endcase
      end
      if (tx_valid && ready_old) begin
        m_hv = 1; m_d = tx_data; m_inv = tx_parity_invert; m_last = tx_last;
      end
      e_tx = cur;
    end
    e_act = (seg != S_NONE);
    e_rdy = !m_hv;
    model_on = 1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("tx", tx, e_tx);
      chk("tx_active", tx_active, e_act);
      chk("tx_underflow", tx_underflow, e_uf);
      chk("tx_ready", tx_ready, e_rdy);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic rec [0:1023];

  function automatic logic sig_act(bit sel); return sel ? d2_active : tx_active; endfunction
  function automatic logic sig_rdy(bit sel); return sel ? d2_ready : tx_ready; endfunction
  function automatic logic sig_tx(bit sel);  return sel ? d2_tx : tx; endfunction
  function automatic logic sig_uf(bit sel);  return sel ? d2_uf : tx_underflow; endfunction

  task automatic send(bit sel, logic [9:0] d, bit inv, bit last);
    int n = 0;
    if (sel) begin d2_data = d; d2_inv = inv; d2_last = last; d2_valid = 1'b1; end
    else begin tx_data = d; tx_parity_invert = inv; tx_last = last; tx_valid = 1'b1; end
    do begin @(negedge clk); n++; end while (!sig_rdy(sel) && n < 3000);
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL send_timeout actual not_ready required ready");
    end
    @(posedge clk); #1;
  endtask

  task automatic drop(bit sel);
    if (sel) d2_valid = 1'b0; else tx_valid = 1'b0;
  endtask

  task automatic measure(bit sel, output int len, output int ufs,
                         output int rises, output int uf_idx);
    int  n = 0;
    bit  prev_r;
    len = 0; ufs = 0; rises = 0; uf_idx = -1;
    do begin @(negedge clk); n++; end while (!sig_act(sel) && n < 5000);
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL frame_start_timeout actual idle required active");
    end
    prev_r = sig_rdy(sel);
    while (sig_act(sel) && len < 1024) begin
      rec[len] = sig_tx(sel);
      if (sig_uf(sel)) begin ufs++; uf_idx = len; end
      if (sig_rdy(sel) && !prev_r) rises++;
      prev_r = sig_rdy(sel);
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, ufs, rises, uf_idx;
    reset_n = 0; tx_valid = 0; tx_data = '0; tx_parity_invert = 0; tx_last = 0;
    d2_valid = 0; d2_data = '0; d2_inv = 0; d2_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx, 0);
    chk("reset_active", tx_active, 0);
    chk("reset_ready", tx_ready, 1);
    chk("reset_uf", tx_underflow, 0);
    @(posedge clk); #1 reset_n = 1;
    repeat (4) @(posedge clk); #1;

    // Single word 10'b10_1010_1010, last
    fork
      measure(0, len, ufs, rises, uf_idx);
      begin send(0, 10'h2AA, 0, 1); drop(0); end
    join
    chk("A_len", len, 368);
    chk("A_ufs", ufs, 0);
    chk("A_rises", rises, 1);
    chk("A_lag_low", rec[0], 0);
    chk("A_pre_high", rec[1], 1);
    chk("A_ones_low", rec[17], 0);
    chk("A_ones_high", rec[25], 1);
    chk("A_start_low", rec[97], 0);
    chk("A_start_high", rec[121], 1);
    chk("A_sync_first", rec[145], 0);
    chk("A_sync_second", rec[153], 1);
    chk("A_parity", rec[330], 1);
    chk("A_end_high", rec[337], 1);
    chk("A_end_low", rec[345], 0);
    chk("A_end_tail", rec[353], 1);
    repeat (5) @(posedge clk); #1;

    // Three words, valid held
    fork
      measure(0, len, ufs, rises, uf_idx);
      begin send(0, 10'h3FF, 0, 0); send(0, 10'h000, 0, 0); send(0, 10'h155, 0, 1); drop(0); end
    join
    chk("B_len", len, 94*H);
    chk("B_rises", rises, 3);
    chk("B_ufs", ufs, 0);
    chk("B_par0", rec[330], 0);
    chk("B_par1", rec[522], 0);
    chk("B_par2", rec[714], 1);
    repeat (5) @(posedge clk); #1;

    // Parity invert on first word only
    fork
      measure(0, len, ufs, rises, uf_idx);
      begin send(0, 10'h2AA, 1, 0); send(0, 10'h2AA, 0, 1); drop(0); end
    join
    chk("C_len", len, 70*H);
    chk("C_par_inv", rec[330], 0);
    chk("C_par_ok", rec[522], 1);
    repeat (5) @(posedge clk); #1;

    // Underflow: non-last word with nothing following
    fork
      measure(0, len, ufs, rises, uf_idx);
      begin send(0, 10'h0F0, 0, 0); drop(0); end
    join
    chk("D_len", len, 368);
    chk("D_ufs", ufs, 1);
    chk("D_uf_idx", uf_idx, 336);
    repeat (5) @(posedge clk); #1;

    // Reset mid-WORD
    send(0, 10'h123, 0, 1); drop(0);
    repeat (200) @(posedge clk);
    #1 reset_n = 0;
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    chk("E_tx", tx, 0);
    chk("E_ready", tx_ready, 1);
    chk("E_active", tx_active, 0);
    @(posedge clk); #1;
    fork
      measure(0, len, ufs, rises, uf_idx);
      begin send(0, 10'h0A5, 0, 1); drop(0); end
    join
    chk("E_len", len, 368);
    repeat (5) @(posedge clk); #1;

    // H=2, odd parity, word 0
    fork
      measure(1, len, ufs, rises, uf_idx);
      begin send(1, 10'h000, 0, 1); drop(1); end
    join
    chk("G_len", len, 92);
    chk("G_sync", rec[39], 1);
    chk("G_bit9_first", rec[41], 1);
    chk("G_bit9_second", rec[43], 0);
    chk("G_par_first", rec[81], 0);
    chk("G_par_second", rec[83], 1);
    repeat (5) @(posedge clk); #1;

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 150);
      send(0, 10'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      if (gap > 0) begin
        drop(0);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    send(0, 10'($urandom), 0, 1);
    drop(0);
    repeat (1000) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
